// File: rtl/ebpf_lsu.sv
// Load/store unit and 64-bit data-memory bus initiator. Sub-word stores use read-modify-write.
// Optional `define LSU_ACK_TIMEOUT_EN bounds each bus phase to TIMEOUT_CYCLES strobe cycles.
module ebpf_lsu #(
  parameter int ADDR_W         = 11,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W+2:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic              stb,
  output logic [ADDR_W-1:0] adr,
  output logic              we,
  output logic [3:0]        ww,
  output logic [63:0]       dat_w,
  input  logic [63:0]       dat_r,
  input  logic              data_ack
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state, state_n;
  logic              stb_n, we_n, resp_valid_n, resp_err_n;
  logic [ADDR_W-1:0] adr_n;
  logic [3:0]        ww_n;
  logic [63:0]       dat_w_n, resp_rdata_n;

  logic              cap_we;
  logic [1:0]        cap_size;
  logic [2:0]        cap_off;
  logic [63:0]       cap_wdata;

  logic              accept, misaligned, timeout;
  logic [63:0]       size_mask, lane, merged;
  logic [5:0]        shamt;

  // Handshake: a request transfers on a cycle where req_valid && req_ready; resp_valid is a one-cycle pulse.
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    size_mask = '1;
    case (cap_size)
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
  end

  // Little-endian lane: byte offset selects the field within the 64-bit word.
  assign shamt  = {cap_off, 3'b000};
  assign lane   = (dat_r >> shamt) & size_mask;
  assign merged = (dat_r & ~(size_mask << shamt)) | ((cap_wdata & size_mask) << shamt);

`ifdef LSU_ACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // Counts strobe cycles within the current phase; a phase change restarts it.
  always_ff @(posedge clk) begin
    if (rst || state_n != state) tmo_cnt <= '0;
    else if (stb)                tmo_cnt <= tmo_cnt + CNT_W'(1);
  end

  assign timeout = stb && !data_ack && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_n      = state;
    stb_n        = stb;
    we_n         = we;
    adr_n        = adr;
    ww_n         = ww;
    dat_w_n      = dat_w;
    resp_valid_n = 1'b0;
    resp_rdata_n = resp_rdata;
    resp_err_n   = resp_err;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_n      = RESP;
            resp_valid_n = 1'b1;
            resp_rdata_n = '0;
            resp_err_n   = 1'b1;
          end else begin
            adr_n = req_addr[ADDR_W+2:3];
            ww_n  = 4'b0001 << req_size;
            stb_n = 1'b1;
            if (req_we && req_size == 2'b11) begin
              state_n = WR;
              we_n    = 1'b1;
              dat_w_n = req_wdata;
            end else begin
              state_n = RD;
              we_n    = 1'b0;
            end
          end
        end
      end
      RD: begin
        if (data_ack) begin
          if (cap_we) begin
            state_n = WR;
            we_n    = 1'b1;
            dat_w_n = merged;
          end else begin
            state_n      = RESP;
            stb_n        = 1'b0;
            resp_valid_n = 1'b1;
            resp_rdata_n = lane;
            resp_err_n   = 1'b0;
          end
        end else if (timeout) begin
          state_n      = RESP;
          stb_n        = 1'b0;
          we_n         = 1'b0;
          resp_valid_n = 1'b1;
          resp_rdata_n = '0;
          resp_err_n   = 1'b1;
        end
      end
      WR: begin
        if (data_ack || timeout) begin
          state_n      = RESP;
          stb_n        = 1'b0;
          we_n         = 1'b0;
          resp_valid_n = 1'b1;
          resp_rdata_n = '0;
          resp_err_n   = !data_ack;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stb        <= 1'b0;
      we         <= 1'b0;
      adr        <= '0;
      ww         <= '0;
      dat_w      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      cap_we     <= 1'b0;
      cap_size   <= '0;
      cap_off    <= '0;
      cap_wdata  <= '0;
    end else begin
      state      <= state_n;
      stb        <= stb_n;
      we         <= we_n;
      adr        <= adr_n;
      ww         <= ww_n;
      dat_w      <= dat_w_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_err   <= resp_err_n;
      if (accept) begin
        cap_we    <= req_we;
        cap_size  <= req_size;
        cap_off   <= req_addr[2:0];
        cap_wdata <= req_wdata;
      end
    end
  end

endmodule
